reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_word.sv | 30 +++
 rtl/reg_file.sv | 75 +++++++
 tb/tb_reg_file.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file.
// Holds the default word width and depth and the byte-lane count helper.
package reg_file_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

   // Number of byte lanes (write strobes) in a word of the given width.
   function automatic int byte_count(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file.
// Synchronous clear wins over load; on load only the strobed byte lanes change.
module reg_word
   import reg_file_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int NB    = byte_count(WIDTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [NB-1:0]    wbe,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear on reset, otherwise update the strobed bytes when loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
               q[8*b +: 8] <= d[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with byte write strobes.
// Reads are combinational. Word 0 can be hardwired to zero (ZERO_REG).
// Optional macro REG_FILE_BYPASS_EN forwards the in-flight write (merged with
// the stored bytes under wbe) to a read port addressing the same word.
module reg_file
   import reg_file_pkg::*;
#(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int NB       = byte_count(WIDTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [NB-1:0]    wbe,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2
);

   logic [WIDTH-1:0] words [DEPTH];

   // Word 0 is a constant when hardwired; every other word is real storage
   // with a one-hot load decoded from the write address.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (ZERO_REG != 0 && i == 0) begin : g_zero
         assign words[i] = '0;
      end else begin : g_store
         reg_word #(
            .WIDTH (WIDTH)
         ) u_word (
            .clk  (clk),
            .rst  (rst),
            .load (we && (waddr == AW'(i))),
            .wbe  (wbe),
            .d    (wdata),
            .q    (words[i])
         );
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // A write is forwardable only if it will actually commit this edge.
   logic fwd_ok;
   assign fwd_ok = we && !rst && ((ZERO_REG == 0) || (waddr != '0));

   // Read ports: stored word, with strobed bytes of a same-address write overlaid.
   always_comb begin
      rdata1 = words[raddr1];
      rdata2 = words[raddr2];
      if (fwd_ok && (raddr1 == waddr)) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) rdata1[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      if (fwd_ok && (raddr2 == waddr)) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) rdata2[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end
`else
   // Read ports: stored word only; a same-cycle write shows after the edge.
   always_comb begin
      rdata1 = words[raddr1];
      rdata2 = words[raddr2];
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: default build (32x32, ZERO_REG=1), a
// ZERO_REG=0 copy, and a WIDTH=16/DEPTH=8 copy, sharing clock and reset.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   // Default instance
   logic        we;
   logic [3:0]  wbe;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata, rdata1, rdata2;

   // ZERO_REG = 0 instance
   logic        z_we;
   logic [3:0]  z_wbe;
   logic [4:0]  z_waddr, z_raddr1, z_raddr2;
   logic [31:0] z_wdata, z_rdata1, z_rdata2;

   // WIDTH = 16, DEPTH = 8 instance
   logic        s_we;
   logic [1:0]  s_wbe;
   logic [2:0]  s_waddr, s_raddr1, s_raddr2;
   logic [15:0] s_wdata, s_rdata1, s_rdata2;

   int checks = 0;
   int errors = 0;

   reg_file dut (
      .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
   );

   reg_file #(.ZERO_REG(0)) dut_z (
      .clk(clk), .rst(rst), .we(z_we), .wbe(z_wbe), .waddr(z_waddr), .wdata(z_wdata),
      .raddr1(z_raddr1), .raddr2(z_raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2)
   );

   reg_file #(.WIDTH(16), .DEPTH(8)) dut_s (
      .clk(clk), .rst(rst), .we(s_we), .wbe(s_wbe), .waddr(s_waddr), .wdata(s_wdata),
      .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      we = 1'b0; wbe = '0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      z_we = 1'b0; z_wbe = '0; z_waddr = '0; z_wdata = '0; z_raddr1 = '0; z_raddr2 = '0;
      s_we = 1'b0; s_wbe = '0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;

      // Reset for one edge, then sweep every address on both ports.
      tick();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         z_raddr1 = 5'(a); z_raddr2 = 5'(31 - a);
         #1;
         chk($sformatf("rst_sweep_p1_a%0d", a), rdata1, 32'h0);
         chk($sformatf("rst_sweep_p2_a%0d", 31 - a), rdata2, 32'h0);
         chk($sformatf("rst_sweep_z_p1_a%0d", a), z_rdata1, 32'h0);
         chk($sformatf("rst_sweep_z_p2_a%0d", 31 - a), z_rdata2, 32'h0);
      end
      for (int a = 0; a < 8; a++) begin
         s_raddr1 = 3'(a); s_raddr2 = 3'(7 - a);
         #1;
         chk($sformatf("rst_sweep_s_p1_a%0d", a), {16'h0, s_rdata1}, 32'h0);
         chk($sformatf("rst_sweep_s_p2_a%0d", 7 - a), {16'h0, s_rdata2}, 32'h0);
      end

      // Full write then single-byte update of address 5.
      tick();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF;
      raddr1 = 5'd5; raddr2 = 5'd5;
      tick();
      we = 1'b0;
      #1;
      chk("full_write_p1", rdata1, 32'hDEADBEEF);
      chk("full_write_p2", rdata2, 32'hDEADBEEF);
      we = 1'b1; wdata = 32'h00005500; wbe = 4'b0010;
      tick();
      we = 1'b0;
      #1;
      chk("byte_write_p1", rdata1, 32'hDEAD55EF);
      chk("byte_write_p2", rdata2, 32'hDEAD55EF);

      // Write enable with no strobes changes nothing.
      we = 1'b1; wdata = 32'h0; wbe = 4'h0;
      tick();
      we = 1'b0;
      #1;
      chk("zero_strobe", rdata1, 32'hDEAD55EF);

      // Address 0: discarded with ZERO_REG=1, stored with ZERO_REG=0.
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF; raddr1 = 5'd0; raddr2 = 5'd1;
      z_we = 1'b1; z_waddr = 5'd0; z_wdata = 32'hFFFFFFFF; z_wbe = 4'hF; z_raddr1 = 5'd0; z_raddr2 = 5'd1;
      #1;
      chk("zero_reg_no_fwd", rdata1, 32'h0);
      chk("zero_off_fwd", z_rdata1, BYP ? 32'hFFFFFFFF : 32'h0);
      tick();
      we = 1'b0; z_we = 1'b0;
      #1;
      chk("zero_reg_p1", rdata1, 32'h0);
      chk("zero_reg_addr1", rdata2, 32'h0);
      chk("zero_off_p1", z_rdata1, 32'hFFFFFFFF);
      chk("zero_off_addr1", z_rdata2, 32'h0);
      raddr2 = 5'd0;
      #1;
      chk("zero_reg_p2", rdata2, 32'h0);
      raddr2 = 5'd5;
      #1;
      chk("addr5_kept", rdata2, 32'hDEAD55EF);

      // Same-cycle write and read of address 7.
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; wbe = 4'hF; raddr1 = 5'd7; raddr2 = 5'd6;
      #1;
      chk("same_cycle_pre", rdata1, BYP ? 32'h12345678 : 32'h0);
      chk("same_cycle_other", rdata2, 32'h0);
      tick();
      we = 1'b0;
      #1;
      chk("same_cycle_post", rdata1, 32'h12345678);

      // Same-cycle partial write: forwarded value merges strobed bytes.
      we = 1'b1; wdata = 32'hFFFFFFAA; wbe = 4'b0001; raddr2 = 5'd7;
      #1;
      chk("merge_pre_p1", rdata1, BYP ? 32'h123456AA : 32'h12345678);
      chk("merge_pre_p2", rdata2, BYP ? 32'h123456AA : 32'h12345678);
      tick();
      we = 1'b0;
      #1;
      chk("merge_post", rdata1, 32'h123456AA);

      // Values hold across idle cycles.
      repeat (5) tick();
      raddr2 = 5'd5;
      #1;
      chk("hold_a7", rdata1, 32'h123456AA);
      chk("hold_a5", rdata2, 32'hDEAD55EF);

      // Reset raised mid-cycle with a simultaneous write to address 3.
      rst = 1'b1;
      we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; wbe = 4'hF; raddr2 = 5'd3;
      #1;
      chk("rst_mid_cycle_a7", rdata1, 32'h123456AA);
      chk("rst_no_fwd_a3", rdata2, 32'h0);
      tick();
      rst = 1'b0; we = 1'b0;
      #1;
      chk("rst_beats_write_a3", rdata2, 32'h0);
      chk("rst_clear_a7", rdata1, 32'h0);
      raddr1 = 5'd5; z_raddr1 = 5'd0;
      #1;
      chk("rst_clear_a5", rdata1, 32'h0);
      chk("rst_clear_z_a0", z_rdata1, 32'h0);

      // Write in the first cycle after reset release, plus the small instance.
      we = 1'b1; waddr = 5'd9; wdata = 32'h0BADF00D; wbe = 4'hF; raddr1 = 5'd9; raddr2 = 5'd8;
      s_we = 1'b1; s_waddr = 3'd6; s_wdata = 16'h1234; s_wbe = 2'b11;
      tick();
      we = 1'b0;
      #1;
      chk("post_rst_write", rdata1, 32'h0BADF00D);
      chk("post_rst_neighbor", rdata2, 32'h0);
      raddr2 = 5'd25;
      #1;
      chk("post_rst_alias", rdata2, 32'h0);
      s_waddr = 3'd7; s_wdata = 16'hBEEF;
      tick();
      s_waddr = 3'd7; s_wdata = 16'hFF11; s_wbe = 2'b01; s_raddr1 = 3'd7;
      s_we = 1'b0;
      s_raddr2 = 3'd6;
      #1;
      chk("small_a7", {16'h0, s_rdata1}, 32'h0000BEEF);
      chk("small_a6", {16'h0, s_rdata2}, 32'h00001234);
      s_we = 1'b1;
      tick();
      s_we = 1'b0;
      #1;
      chk("small_byte", {16'h0, s_rdata1}, 32'h0000BE11);
      s_raddr2 = 3'd0;
      #1;
      chk("small_zero", {16'h0, s_rdata2}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
